serial_word_receiver: RTL

Serial-to-parallel receiver: collects N serial bits into one parallel word and presents it on a valid/ready output port. It is the receiving end of the shift-register serial link. It frames words with a `start` strobe, accepts bits on a `bit_en` qualifier, and supports MSB-first (left shift) or LSB-first (right shift) ordering. It detects and flags overrun when the consumer has not taken the previous word.

---
 rtl/serial_rx_pkg.sv | 13 +
 rtl/serial_word_receiver_if.sv | 25 ++
 rtl/sipo_shift_core.sv | 45 ++++
 rtl/serial_word_receiver.sv | 116 +++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
// Bit-order encoding matches the dir input pin.
package serial_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial-in / parallel-out bundle; master drives serial bits and ready, slave returns the word.
// Parallel side is valid/ready: q is held stable while valid is high and ready is low.
interface serial_word_receiver_if #(
  parameter int N = 8
);
  logic         dir;
  logic         start;
  logic         bit_en;
  logic         s_in;
  logic         ready;
  logic [N-1:0] q;
  logic         valid;
  logic         busy;
  logic         overrun;

  modport master (
    output dir, start, bit_en, s_in, ready,
    input  q, valid, busy, overrun
  );

  modport slave (
    input  dir, start, bit_en, s_in, ready,
    output q, valid, busy, overrun
  );
endinterface

// File: rtl/sipo_shift_core.sv
// N-bit serial-in shift register; dir selects left (bit enters LSB) or right (bit enters MSB) shift.
// sh_shifted is the value the register takes on an enabled edge, so a caller can capture the final word in the same cycle.
module sipo_shift_core
  import serial_rx_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         dir,
  input  logic         s_in,
  output logic [N-1:0] sh_shifted
);

  logic [N-1:0] sh_q;
  logic [N-1:0] sh_d;

  always_comb begin
    if (dir == DIR_LSB_FIRST) begin
      sh_shifted = {s_in, sh_q[N-1:1]};
    end else begin
      sh_shifted = {sh_q[N-2:0], s_in};
    end
  end

  always_comb begin
    sh_d = sh_q;
    if (clr) begin
      sh_d = '0;
    end else if (en) begin
      sh_d = sh_shifted;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Frames N serial bits after a start strobe into a word on a valid/ready port; q/valid update on the final bit's edge.
// A word completing while the previous one is still unconsumed is dropped and sets the sticky overrun flag.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  serial_word_receiver_if.slave  rx
);

  localparam int              CNT_W    = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [N-1:0]     word_q, word_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             sh_clr;
  logic             sh_en;
  logic [N-1:0]     sh_shifted;

  sipo_shift_core #(
    .N (N)
  ) u_shift (
    .clock      (clock),
    .reset      (reset),
    .clr        (sh_clr),
    .en         (sh_en),
    .dir        (dir_q),
    .s_in       (rx.s_in),
    .sh_shifted (sh_shifted)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    sh_clr    = 1'b0;
    sh_en     = 1'b0;

    if (valid_q && rx.ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (rx.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          dir_d   = rx.dir;
          sh_clr  = 1'b1;
        end
      end
      SHIFT: begin
        // start outranks bit_en: a colliding bit belongs to the aborted word
        if (rx.start) begin
          cnt_d  = '0;
          dir_d  = rx.dir;
          sh_clr = 1'b1;
        end else if (rx.bit_en) begin
          sh_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (!valid_q || rx.ready) begin
              word_d  = sh_shifted;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= DIR_MSB_FIRST;
      word_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx.q       = word_q;
  assign rx.valid   = valid_q;
  assign rx.busy    = busy_q;
  assign rx.overrun = overrun_q;

endmodule
